multimode_ring_counter: RTL
===========================

MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_FLOPS, default 4, meaning counter width N (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops SHALL be rising-edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port en, input, 1, shift enable.
REQ-005 The block SHALL have port dir, input, 1, shift direction: 0 = toward MSB, 1 = toward LSB.
REQ-006 The block SHALL have port mode, input, 1 (package type), 0 = MODE_RING (one-hot rotate), 1 = MODE_TWISTED (Johnson).
REQ-007 The block SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-008 The block SHALL have port load_val, input, N, the value captured on load.
REQ-009 The block SHALL have port q, output, N, the registered counter state.
REQ-010 The block SHALL have port q_out, output, 1, equal to q[N-1].
REQ-011 The block SHALL have port tc, output, 1, registered terminal-count pulse.
REQ-012 The block SHALL have port illegal, output, 1, registered one-cycle flag: the state was corrected.

Function
REQ-013 HOME SHALL be the N-bit value with only bit 0 set; it is legal in both modes.
REQ-014 The per-cycle priority SHALL be: load > correction > shift > hold.
REQ-015 When load=1, q SHALL take load_val verbatim on the next edge, with no legality check; tc and illegal SHALL be 0.
REQ-016 The ring-legal condition SHALL be exactly one bit of q set.
REQ-017 The twisted-legal condition SHALL be that the circular count of i with q[i] != q[(i+1) mod N] is 0 or 2.
REQ-018 When load=0, en=1 and q is illegal for the current mode, q SHALL become HOME and illegal SHALL be 1 the next cycle, with no shift.
REQ-019 When load=0, en=1, q is legal and dir=0, q SHALL become {q[N-2:0], fb}, where fb = q[N-1] (ring) or ~q[N-1] (twisted).
REQ-020 When load=0, en=1, q is legal and dir=1, q SHALL become {fb, q[N-1:1]}, where fb = q[0] (ring) or ~q[0] (twisted).
REQ-021 When en=0 and load=0, q SHALL hold, with tc=0 and illegal=0; no correction SHALL occur while disabled.
REQ-022 tc SHALL be 1 in exactly the cycles where q became HOME through a shift (REQ-019/020), never through load, correction or reset.
REQ-023 The sequence period from HOME SHALL be N shifts in ring mode and 2N shifts in twisted mode, in either direction.
REQ-024 mode and dir MAY change on any cycle; the next shift SHALL use the new values, and a state that is illegal in the new mode SHALL be corrected per REQ-018.
REQ-025 Latency SHALL be one cycle from any input to q, tc and illegal; no output SHALL be combinational from inputs.

Reset
REQ-026 When rst=0, the block SHALL asynchronously set q=HOME, tc=0 and illegal=0, so q_out=0 for N>=2.
REQ-027 Reset deassertion SHALL be sampled synchronously by downstream logic; the first shift SHALL occur on the first edge with rst=1 and en=1.
REQ-028 Reset asserted mid-sequence SHALL override load and en immediately.

Structure
REQ-029 Package ring_counter_pkg SHALL hold the typedef enum counter_mode_t {MODE_RING, MODE_TWISTED}.
REQ-030 Package ring_counter_pkg SHALL hold the function home_value(N).
REQ-031 Sub-module ring_state_check SHALL be combinational, parameterised by N, with inputs q and mode and output legal.
REQ-032 State, tc and illegal SHALL be held in a single always_ff block.

Verification (N=4)
REQ-033 Test: reset, ring mode, dir=0, en=1 for 8 cycles -> q = 0010, 0100, 1000, 0001 (repeated), with tc=1 on each 0001.
REQ-034 Test: twisted mode, dir=0, 8 shifts from HOME -> 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001, with tc only on the last.
REQ-035 Test: twisted mode, dir=1, from HOME -> 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, with tc on the 8th.
REQ-036 Test: load 0101 in ring mode, then en=1 -> q=0101 for one cycle, then q=0001 with illegal=1 and tc=0.
REQ-037 Test: at q=0011 (twisted), switch mode to ring with en=1 -> q=0001 and illegal=1; a following shift -> q=0010.
REQ-038 Test: assert rst low between clock edges while q=1000 -> q=0001 immediately, and load/en are ignored until release.

Source files
------------

// File: rtl/ring_counter_pkg.sv
// Shared types and constants for the multimode ring/Johnson counter.
package ring_counter_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_TWISTED = 1'b1
    } counter_mode_t;

    // Reset/home state: only bit 0 set, legal in both modes.
    function automatic logic [31:0] home_value(input int unsigned n);
        logic [31:0] v;
        v = '0;
        if (n > 0) v[0] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check of a counter state for the selected mode.
module ring_state_check
    import ring_counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]  q,
    input  counter_mode_t mode,
    output logic          legal
);

    logic [5:0] w_ones;
    logic [5:0] w_trans;

    always_comb begin
        w_ones  = '0;
        w_trans = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_ones  = w_ones + 6'(q[i]);
            // Circular neighbour compare; a Johnson state has 0 or 2 edges.
            w_trans = w_trans + 6'(q[i] ^ q[(i + 1) % N]);
        end
        if (mode == MODE_RING) begin
            legal = (w_ones == 6'd1);
        end else begin
            legal = (w_trans == 6'd0) || (w_trans == 6'd2);
        end
    end

endmodule

// File: rtl/multimode_ring_counter.sv
// One-hot ring / Johnson counter with direction, parallel load,
// self-correction of illegal states and a terminal-count pulse.
module multimode_ring_counter
    import ring_counter_pkg::*;
#(
    parameter int NUMBER_OF_FLOPS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       dir,
    input  counter_mode_t              mode,
    input  logic                       load,
    input  logic [NUMBER_OF_FLOPS-1:0] load_val,
    output logic [NUMBER_OF_FLOPS-1:0] q,
    output logic                       q_out,
    output logic                       tc,
    output logic                       illegal
);

    localparam int N = NUMBER_OF_FLOPS;
    localparam logic [N-1:0] HOME = N'(home_value(N));

    logic [N-1:0] r_q;
    logic         r_tc;
    logic         r_illegal;

    logic         w_legal;
    logic         w_fb;
    logic [N-1:0] w_shift;

    ring_state_check #(.N(N)) u_check (
        .q     (r_q),
        .mode  (mode),
        .legal (w_legal)
    );

    always_comb begin
        w_fb    = 1'b0;
        w_shift = r_q;
        if (dir == 1'b0) begin
            w_fb    = (mode == MODE_TWISTED) ? ~r_q[N-1] : r_q[N-1];
            w_shift = {r_q[N-2:0], w_fb};
        end else begin
            w_fb    = (mode == MODE_TWISTED) ? ~r_q[0] : r_q[0];
            w_shift = {w_fb, r_q[N-1:1]};
        end
    end

    // Priority: load, then correction, then shift, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q       <= HOME;
            r_tc      <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_tc      <= 1'b0;
            r_illegal <= 1'b0;
            if (load) begin
                r_q <= load_val;
            end else if (en) begin
                if (!w_legal) begin
                    r_q       <= HOME;
                    r_illegal <= 1'b1;
                end else begin
                    r_q  <= w_shift;
                    r_tc <= (w_shift == HOME);
                end
            end
        end
    end

    assign q       = r_q;
    assign q_out   = r_q[N-1];
    assign tc      = r_tc;
    assign illegal = r_illegal;

endmodule
